// File: rtl/sccb_cfg_pkg.sv
// rtl/sccb_cfg_pkg.sv - shared state type, marker defaults and {reg,val} entry slicing
package sccb_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WRITE,
        S_RESP,
        S_DELAY,
        S_FINISH,
        S_FAIL
    } state_t;

    localparam logic [15:0] DEF_END_MARK   = 16'hFFFF;
    localparam logic [15:0] DEF_DELAY_MARK = 16'hFFF0;

    // Entries are packed {reg, val}; val occupies the low val_w bits.
    function automatic logic [31:0] entry_val(input logic [63:0] entry, input int val_w);
        logic [63:0] mask;
        mask = (64'd1 << val_w) - 64'd1;
        return 32'(entry & mask);
    endfunction

    function automatic logic [31:0] entry_reg(input logic [63:0] entry, input int val_w);
        return 32'(entry >> val_w);
    endfunction

endpackage

// File: rtl/sccb_cfg_delay_timer.sv
// rtl/sccb_cfg_delay_timer.sv - loadable down-counter for DELAY pauses and ROM latency waits
module sccb_cfg_delay_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// rtl/sccb_cfg_sequencer.sv - walks a {reg,val} config ROM and issues SCCB writes
// Optional NACK retry enabled by CFG_RETRY_EN.
module sccb_cfg_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int REG_W     = 8,
    parameter int VAL_W     = 8,
    parameter int ROM_LAT   = 1,
    parameter int DELAY_CYC = 1000000,
    parameter logic [REG_W+VAL_W-1:0] END_MARK   = (REG_W+VAL_W)'(DEF_END_MARK),
    parameter logic [REG_W+VAL_W-1:0] DELAY_MARK = (REG_W+VAL_W)'(DEF_DELAY_MARK),
    parameter int MAX_RETRY = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [REG_W+VAL_W-1:0] rom_data,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [REG_W-1:0]       wr_reg,
    output logic [VAL_W-1:0]       wr_val,
    input  logic                   wr_done,
    input  logic                   wr_nack,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_W:0]        wr_count
);

    localparam int TW = $clog2(DELAY_CYC + ROM_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t        state, state_nx;
    logic          timer_load, timer_expired;
    logic [TW-1:0] timer_val;
    logic          clr_run, latch_wr, inc_addr, inc_count;
    logic          at_last;

`ifdef CFG_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    logic [RW-1:0] retry_cnt;
    logic          clr_retry, inc_retry;
`else
    logic unused_max_retry;
    assign unused_max_retry = |MAX_RETRY;
`endif

    assign at_last  = (rom_addr == LAST_ADDR);
    assign wr_valid = (state == S_WRITE);
    assign busy     = !(state inside {S_IDLE, S_FINISH, S_FAIL});

    sccb_cfg_delay_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        timer_load = 1'b0;
        timer_val  = TW'(ROM_LAT - 1);
        clr_run    = 1'b0;
        latch_wr   = 1'b0;
        inc_addr   = 1'b0;
        inc_count  = 1'b0;
`ifdef CFG_RETRY_EN
        clr_retry  = 1'b0;
        inc_retry  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    clr_run    = 1'b1;
                    timer_load = 1'b1;
                    state_nx   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (timer_expired) state_nx = S_DECODE;
            end
            S_DECODE: begin
`ifdef CFG_RETRY_EN
                clr_retry = 1'b1;
`endif
                if (rom_data == END_MARK) begin
                    state_nx = S_FINISH;
                end else if (rom_data == DELAY_MARK) begin
                    timer_load = 1'b1;
                    timer_val  = TW'(DELAY_CYC - 1);
                    state_nx   = S_DELAY;
                end else begin
                    latch_wr = 1'b1;
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_ready) state_nx = S_RESP;
            end
            S_RESP: begin
                if (wr_done) begin
                    if (!wr_nack) begin
                        inc_count = 1'b1;
                        if (at_last) begin
                            state_nx = S_FINISH;
                        end else begin
                            inc_addr   = 1'b1;
                            timer_load = 1'b1;
                            state_nx   = S_FETCH;
                        end
                    end else begin
`ifdef CFG_RETRY_EN
                        if (retry_cnt < RETRY_LIMIT) begin
                            inc_retry = 1'b1;
                            state_nx  = S_WRITE;
                        end else begin
                            state_nx = S_FAIL;
                        end
`else
                        state_nx = S_FAIL;
`endif
                    end
                end
            end
            S_DELAY: begin
                if (timer_expired) begin
                    if (at_last) begin
                        state_nx = S_FINISH;
                    end else begin
                        inc_addr   = 1'b1;
                        timer_load = 1'b1;
                        state_nx   = S_FETCH;
                    end
                end
            end
            S_FINISH: state_nx = S_IDLE;
            S_FAIL:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // rom_addr is left on the failing entry so software can report it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            wr_reg   <= '0;
            wr_val   <= '0;
            wr_count <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            if (clr_run) begin
                rom_addr <= '0;
                wr_count <= '0;
                done     <= 1'b0;
                error    <= 1'b0;
            end
            if (inc_addr)  rom_addr <= rom_addr + 1'b1;
            if (inc_count) wr_count <= wr_count + 1'b1;
            if (latch_wr) begin
                wr_reg <= REG_W'(entry_reg(64'(rom_data), VAL_W));
                wr_val <= VAL_W'(entry_val(64'(rom_data), VAL_W));
            end
            if (state_nx == S_FINISH) done  <= 1'b1;
            if (state_nx == S_FAIL)   error <= 1'b1;
        end
    end

`ifdef CFG_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= '0;
        end else if (clr_retry) begin
            retry_cnt <= '0;
        end else if (inc_retry) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`endif

endmodule
